// File: rtl/ram_pkg.sv
// Shared constants for the word-addressed RAM: data width, default base address and size,
// plus the index-width helper used by the RAM and its address decoder.
package ram_pkg;

  localparam int XLEN = 32;
  localparam int DEFAULT_MEM_SIZE = 16384;
  localparam logic [XLEN-1:0] DEFAULT_START_ADDR = 32'h8000_0000;

  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/ram_addr_decode.sv
// Maps a byte address onto {in_range, word_index} relative to the RAM base address.
module ram_addr_decode
  import ram_pkg::*;
#(
  parameter logic [XLEN-1:0] START_ADDR = DEFAULT_START_ADDR,
  parameter int              MEM_SIZE   = DEFAULT_MEM_SIZE,
  parameter int              IDX_W      = idx_width(MEM_SIZE / 4)
) (
  input  logic [XLEN-1:0]  addr,
  output logic             in_range,
  output logic [IDX_W-1:0] word_index
);

  logic [XLEN-1:0] offset;

  // Wrapping subtraction folds both bounds into one unsigned compare.
  always_comb begin
    offset     = addr - START_ADDR;
    in_range   = offset < XLEN'(MEM_SIZE);
    word_index = offset[IDX_W+1:2];
  end

endmodule

// File: rtl/ram.sv
// Dual-port word RAM: port 1 reads combinationally, port 2 reads combinationally and writes on clk.
// Contents are never cleared by reset, so images preloaded into mem survive it.
module ram
  import ram_pkg::*;
#(
  parameter int              MEM_SIZE   = DEFAULT_MEM_SIZE,
  parameter logic [XLEN-1:0] START_ADDR = DEFAULT_START_ADDR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] addr1,
  output logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] addr2,
  input  logic            we2,
  input  logic [XLEN-1:0] wd2,
  output logic [XLEN-1:0] rd2
);

  localparam int DEPTH = MEM_SIZE / 4;
  localparam int IDX_W = idx_width(DEPTH);

  if ((MEM_SIZE <= 0) || ((MEM_SIZE % 4) != 0)) begin : g_bad_size
    $error("ram: MEM_SIZE must be a non-zero multiple of 4");
  end

  logic [XLEN-1:0] mem [0:DEPTH-1];

  logic             in_range1;
  logic             in_range2;
  logic [IDX_W-1:0] idx1;
  logic [IDX_W-1:0] idx2;
  logic             wr_en;

  ram_addr_decode #(
    .START_ADDR (START_ADDR),
    .MEM_SIZE   (MEM_SIZE),
    .IDX_W      (IDX_W)
  ) u_dec1 (
    .addr       (addr1),
    .in_range   (in_range1),
    .word_index (idx1)
  );

  ram_addr_decode #(
    .START_ADDR (START_ADDR),
    .MEM_SIZE   (MEM_SIZE),
    .IDX_W      (IDX_W)
  ) u_dec2 (
    .addr       (addr2),
    .in_range   (in_range2),
    .word_index (idx2)
  );

  always_comb begin
    rd1   = in_range1 ? mem[idx1] : '0;
    rd2   = in_range2 ? mem[idx2] : '0;
    wr_en = we2 && in_range2;
  end

  // No bypass: readers see the new word only after the edge that stores it.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[idx2] <= wd2;
    end
  end

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a word-array reference model.
module tb_ram;

  localparam int          MEM_SIZE  = 16384;
  localparam int          MEM_WORDS = MEM_SIZE / 4;
  localparam logic [31:0] START     = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr1;
  logic [31:0] rd1;
  logic [31:0] addr2;
  logic        we2;
  logic [31:0] wd2;
  logic [31:0] rd2;

  int total_checks = 0;
  int bad_checks   = 0;

  logic [31:0] model [MEM_WORDS];

  typedef struct {
    string       name;
    logic        we2;
    logic [31:0] addr2;
    logic [31:0] wd2;
    logic [31:0] addr1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_rd1;
  } vec_t;

  vec_t vecs [$];

  ram #(
    .MEM_SIZE   (MEM_SIZE),
    .START_ADDR (START)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr1 (addr1),
    .rd1   (rd1),
    .addr2 (addr2),
    .we2   (we2),
    .wd2   (wd2),
    .rd2   (rd2)
  );

  always #5 clk = ~clk;

  // Reference model: a byte address is valid when it lies in [START, START+MEM_SIZE).
  function automatic bit model_in_range(input logic [31:0] a);
    longint unsigned lo = longint'(START);
    longint unsigned hi = longint'(START) + longint'(MEM_SIZE);
    longint unsigned x  = longint'(a);
    return (x >= lo) && (x < hi);
  endfunction

  function automatic int model_word(input logic [31:0] a);
    return int'((longint'(a) - longint'(START)) / 4);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (model_in_range(a)) return model[model_word(a)];
    return 32'h0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  // Advance one rising edge, apply the write rule to the model, then settle.
  task automatic clockEdge();
    @(posedge clk);
    if (we2 && !reset && model_in_range(addr2)) model[model_word(addr2)] = wd2;
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a2,
                               input logic [31:0] d2, input logic [31:0] a1);
    @(negedge clk);
    reset = r;
    we2   = w;
    addr2 = a2;
    wd2   = d2;
    addr1 = a1;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    we2   = 1'b0;
    addr1 = START;
    addr2 = START;
    wd2   = 32'h0;

    for (int i = 0; i < MEM_WORDS; i++) begin
      dut.mem[i] = 32'h0;
      model[i]   = 32'h0;
    end
    dut.mem[0] = 32'h0500_006F;
    model[0]   = 32'h0500_006F;
    #1;

    // Preloaded word is visible with no clock edge, even while reset is held.
    checkOutput("preload_rd2", rd2, 32'h0500_006F);
    checkOutput("preload_rd1", rd1, 32'h0500_006F);

    // Write attempt under reset is suppressed.
    applyStimulus(1'b1, 1'b1, START, 32'hFFFF_FFFF, START);
    clockEdge();
    we2 = 1'b0;
    #1;
    checkOutput("reset_blocks_write", rd2, 32'h0500_006F);

    applyStimulus(1'b0, 1'b0, START, 32'h0, START);
    checkOutput("preload_after_reset", rd2, 32'h0500_006F);

    // Held write enable over ten edges rewrites the same value harmlessly.
    applyStimulus(1'b0, 1'b1, START, 32'h1234_5678, START);
    for (int i = 0; i < 10; i++) clockEdge();
    applyStimulus(1'b0, 1'b0, START, 32'h0, START);
    checkOutput("held_write_rd2", rd2, 32'h1234_5678);
    checkOutput("held_write_rd1", rd1, 32'h1234_5678);

    vecs.push_back('{"below_base",     1'b0, 32'h7FFF_FFFC, 32'h0,          32'h8000_0000, 32'h0,          32'h1234_5678});
    vecs.push_back('{"past_end",       1'b0, 32'h8000_4000, 32'h0,          32'h8000_0004, 32'h0,          32'h0});
    vecs.push_back('{"oob_write",      1'b1, 32'h8000_4000, 32'hAAAA_AAAA,  32'h8000_3FFC, 32'h0,          32'h0});
    vecs.push_back('{"last_word",      1'b1, 32'h8000_3FFC, 32'hDEAD_BEEF,  32'h8000_3FFE, 32'hDEAD_BEEF,  32'hDEAD_BEEF});
    vecs.push_back('{"low_bits_ign",   1'b0, 32'h8000_3FFE, 32'h0,          32'hFFFF_FFFC, 32'hDEAD_BEEF,  32'h0});
    vecs.push_back('{"mid_write",      1'b1, 32'h8000_0010, 32'hCAFE_F00D,  32'h8000_0013, 32'hCAFE_F00D,  32'hCAFE_F00D});
    vecs.push_back('{"addr_zero",      1'b0, 32'h0000_0000, 32'h0,          32'h8000_0010, 32'h0,          32'hCAFE_F00D});
    vecs.push_back('{"unaligned_wr",   1'b1, 32'h8000_0021, 32'h1111_1111,  32'h8000_0020, 32'h1111_1111,  32'h1111_1111});

    foreach (vecs[i]) begin
      applyStimulus(1'b0, vecs[i].we2, vecs[i].addr2, vecs[i].wd2, vecs[i].addr1);
      if (vecs[i].we2) begin
        clockEdge();
        we2 = 1'b0;
        #1;
      end
      checkOutput({vecs[i].name, "_rd2"}, rd2, vecs[i].exp_rd2);
      checkOutput({vecs[i].name, "_rd1"}, rd1, vecs[i].exp_rd1);
    end

    // Same-edge: port 1 sees old data before the edge, new data after it.
    applyStimulus(1'b0, 1'b1, 32'h8000_0020, 32'hA5A5_A5A5, 32'h8000_0020);
    checkOutput("same_edge_rd1_before", rd1, 32'h1111_1111);
    checkOutput("same_edge_rd2_before", rd2, 32'h1111_1111);
    clockEdge();
    checkOutput("same_edge_rd1_after", rd1, 32'hA5A5_A5A5);
    checkOutput("same_edge_rd2_after", rd2, 32'hA5A5_A5A5);

    // Reset pulsed and dropped between edges leaves no residue; next edge writes.
    applyStimulus(1'b1, 1'b1, 32'h8000_0030, 32'h5555_0000, 32'h8000_0030);
    #2;
    reset = 1'b0;
    clockEdge();
    checkOutput("reset_released_write", rd1, 32'h5555_0000);

    // Randomized traffic concentrated near the base and end of the array.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a1;
      logic [31:0] a2;
      logic        r;
      case ($urandom_range(0, 9))
        0:       a2 = $urandom;
        1:       a2 = START + MEM_SIZE - 32'($urandom_range(0, 16)) + 32'($urandom_range(0, 8));
        2:       a2 = START - 32'($urandom_range(0, 8));
        default: a2 = START + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      endcase
      a1 = ($urandom_range(0, 1) == 0) ? a2 : START + 32'($urandom_range(0, 63) * 4);
      r  = ($urandom_range(0, 15) == 0);
      applyStimulus(r, 1'($urandom_range(0, 1)), a2, $urandom, a1);
      checkOutput("rand_rd1_pre", rd1, model_read(addr1));
      checkOutput("rand_rd2_pre", rd2, model_read(addr2));
      clockEdge();
      checkOutput("rand_rd2_post", rd2, model_read(addr2));
    end

    // Full sweep: every word must match the model, proving no stray writes.
    applyStimulus(1'b0, 1'b0, START, 32'h0, START);
    for (int i = 0; i < MEM_WORDS; i++) begin
      addr1 = START + 32'(i * 4);
      #1;
      checkOutput("sweep_rd1", rd1, model[i]);
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
